// File: rtl/mux_out_filter.sv
// Synchronizes the raw 2:1 mux output and rejects pulses shorter than STABLE_CYCLES samples.
// Optional MUXF_GLITCH_LEN_EN keeps a register with the length of the last rejected pulse.
module mux_out_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             z_in,
  input  logic             clr,
  output logic             z_filt,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic [CNT_W-1:0] edge_cnt,
  output logic [CNT_W-1:0] glitch_cnt,
  output logic [CNT_W-1:0] glitch_len
);

  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO,
    CHK_HI,
    STABLE_HI,
    CHK_LO
  } state_t;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state;
  logic [RUN_W-1:0]       run;
  logic                   accept;
  logic                   reject;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], z_in};
    end
  end

  assign s = sync[SYNC_STAGES-1];

  // A candidate level is accepted on its STABLE_CYCLES-th consecutive sample and
  // rejected as soon as the synchronized input falls back to the held level.
  assign accept = ((state == CHK_HI && s) || (state == CHK_LO && !s)) && (run == RUN_LAST);
  assign reject = (state == CHK_HI && !s) || (state == CHK_LO && s);
  assign busy   = (state == CHK_HI) || (state == CHK_LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STABLE_LO;
      run    <= '0;
      z_filt <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      case (state)
        STABLE_LO: begin
          if (s) begin
            state <= CHK_HI;
            run   <= RUN_W'(1);
          end
        end
        CHK_HI: begin
          if (!s) begin
            state <= STABLE_LO;
            run   <= '0;
          end else if (run == RUN_LAST) begin
            state  <= STABLE_HI;
            run    <= '0;
            z_filt <= 1'b1;
            rise   <= 1'b1;
          end else begin
            run <= run + RUN_W'(1);
          end
        end
        STABLE_HI: begin
          if (!s) begin
            state <= CHK_LO;
            run   <= RUN_W'(1);
          end
        end
        CHK_LO: begin
          if (s) begin
            state <= STABLE_HI;
            run   <= '0;
          end else if (run == RUN_LAST) begin
            state  <= STABLE_LO;
            run    <= '0;
            z_filt <= 1'b0;
            fall   <= 1'b1;
          end else begin
            run <= run + RUN_W'(1);
          end
        end
        default: begin
          state <= STABLE_LO;
          run   <= '0;
        end
      endcase
    end
  end

  // Counters saturate at all-ones; clr overrides any same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt   <= '0;
      glitch_cnt <= '0;
    end else if (clr) begin
      edge_cnt   <= '0;
      glitch_cnt <= '0;
    end else begin
      if (accept && (edge_cnt != '1)) begin
        edge_cnt <= edge_cnt + CNT_W'(1);
      end
      if (reject && (glitch_cnt != '1)) begin
        glitch_cnt <= glitch_cnt + CNT_W'(1);
      end
    end
  end

`ifdef MUXF_GLITCH_LEN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_len <= '0;
    end else if (clr) begin
      glitch_len <= '0;
    end else if (reject) begin
      glitch_len <= CNT_W'(run);
    end
  end
`else
  assign glitch_len = '0;
`endif

endmodule

// File: tb/tb_mux_out_filter.sv
// Randomized self-checking bench for mux_out_filter against a sample-counting reference model.
// Expected glitch_len follows MUXF_GLITCH_LEN_EN when the bench is built with it.
module tb_mux_out_filter;

  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 4;
  localparam int CNT_W         = 4;
  localparam int MAXC          = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             z_in;
  logic             clr;
  logic             z_filt;
  logic             rise;
  logic             fall;
  logic             busy;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] glitch_cnt;
  logic [CNT_W-1:0] glitch_len;

  int assertCount = 0;
  int failCount   = 0;

  mux_out_filter #(
    .SYNC_STAGES  (SYNC_STAGES),
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .z_in      (z_in),
    .clr       (clr),
    .z_filt    (z_filt),
    .rise      (rise),
    .fall      (fall),
    .busy      (busy),
    .edge_cnt  (edge_cnt),
    .glitch_cnt(glitch_cnt),
    .glitch_len(glitch_len)
  );

  always #5 clk = ~clk;

  // Reference: the filtered level flips once STABLE_CYCLES samples in a row disagree with it;
  // a shorter disagreeing run is a glitch whose length is the number of disagreeing samples.
  bit pipe[$];
  bit mLevel    = 1'b0;
  int mPend     = 0;
  int mEdges    = 0;
  int mGlitches = 0;
  int mLen      = 0;
  bit mRise     = 1'b0;
  bit mFall     = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    bit sample;
    if (!rst_n) begin
      pipe.delete();
      mLevel    = 1'b0;
      mPend     = 0;
      mEdges    = 0;
      mGlitches = 0;
      mLen      = 0;
      mRise     = 1'b0;
      mFall     = 1'b0;
    end else begin
      while (pipe.size() < SYNC_STAGES) pipe.push_back(1'b0);
      sample = pipe.pop_front();
      pipe.push_back(z_in);
      mRise = 1'b0;
      mFall = 1'b0;
      if (sample != mLevel) begin
        mPend++;
        if (mPend == STABLE_CYCLES) begin
          mLevel = sample;
          mPend  = 0;
          if (mEdges < MAXC) mEdges++;
          if (sample) mRise = 1'b1;
          else        mFall = 1'b1;
        end
      end else if (mPend > 0) begin
        if (mGlitches < MAXC) mGlitches++;
        mLen  = mPend;
        mPend = 0;
      end
      if (clr) begin
        mEdges    = 0;
        mGlitches = 0;
        mLen      = 0;
      end
    end
  end

  function automatic int expectedLen(int len);
`ifdef MUXF_GLITCH_LEN_EN
    return len;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, actual, expected);
    end
  endtask

  task automatic compareAll();
    checkOutput("z_filt",     32'(z_filt),     32'(mLevel));
    checkOutput("rise",       32'(rise),       32'(mRise));
    checkOutput("fall",       32'(fall),       32'(mFall));
    checkOutput("busy",       32'(busy),       32'(mPend > 0));
    checkOutput("edge_cnt",   32'(edge_cnt),   32'(mEdges));
    checkOutput("glitch_cnt", 32'(glitch_cnt), 32'(mGlitches));
    checkOutput("glitch_len", 32'(glitch_len), 32'(expectedLen(mLen)));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_outs"}, {25'd0, z_filt, rise, fall, busy, 3'd0},  32'd0);
    checkOutput({tag, "_cnts"}, 32'({edge_cnt, glitch_cnt, glitch_len}), 32'd0);
  endtask

  // Inputs change on the falling edge; outputs are compared on the following falling edge.
  task automatic applyStimulus(input logic z, input logic c, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      z_in = z;
      clr  = c;
      @(posedge clk);
      @(negedge clk);
      compareAll();
    end
    clr = 1'b0;
  endtask

  // Hold reset for two cycles with z_in high, release, and step through the first acceptance.
  task automatic releaseAndCheck(input string tag);
    z_in = 1'b1;
    clr  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkAllZero({tag, "_held"});
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      compareAll();
      checkOutput($sformatf("%s_busy_e%0d", tag, k), 32'(busy),   32'(k >= 3 && k <= 5));
      checkOutput($sformatf("%s_zf_e%0d", tag, k),   32'(z_filt), 32'(k == 6));
      checkOutput($sformatf("%s_rise_e%0d", tag, k), 32'(rise),   32'(k == 6));
    end
    checkOutput({tag, "_edge_cnt"}, 32'(edge_cnt), 32'd1);
    applyStimulus(1'b1, 1'b0, 1);
    checkOutput({tag, "_rise_once"}, 32'(rise), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    z_in  = 1'b1;
    clr   = 1'b0;
    #1;
    checkAllZero("reset_async");

    releaseAndCheck("t1");

    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("t2_fall_edges", 32'(edge_cnt), 32'd2);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("t2_glitch_cnt", 32'(glitch_cnt), 32'd1);
    checkOutput("t2_glitch_len", 32'(glitch_len), 32'(expectedLen(2)));
    checkOutput("t2_z_filt",     32'(z_filt),     32'd0);

    applyStimulus(1'b1, 1'b0, 3);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("t3_glitch_cnt", 32'(glitch_cnt), 32'd2);
    checkOutput("t3_glitch_len", 32'(glitch_len), 32'(expectedLen(3)));
    applyStimulus(1'b1, 1'b0, 4);
    applyStimulus(1'b0, 1'b0, 8);
    checkOutput("t3_edge_cnt",   32'(edge_cnt),   32'd4);
    checkOutput("t3_glitch_kept", 32'(glitch_cnt), 32'd2);

    for (int g = 0; g < 20; g++) begin
      applyStimulus(1'b1, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 4);
    end
    checkOutput("t4_glitch_sat", 32'(glitch_cnt), 32'(MAXC));
    applyStimulus(1'b0, 1'b0, 4);
    checkOutput("t4_glitch_hold", 32'(glitch_cnt), 32'(MAXC));

    // The rejection of a two-sample pulse lands on the fourth edge after it starts.
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("t5_clr_cnt", 32'(glitch_cnt), 32'd0);
    checkOutput("t5_clr_len", 32'(glitch_len), 32'd0);
    applyStimulus(1'b0, 1'b0, 3);
    applyStimulus(1'b1, 1'b0, 2);
    applyStimulus(1'b0, 1'b0, 6);
    checkOutput("t5_next_glitch", 32'(glitch_cnt), 32'd1);

    for (int seg = 0; seg < 80; seg++) begin
      logic lvl;
      int   len;
      lvl = 1'($urandom_range(0, 1));
      len = int'($urandom_range(1, 7));
      for (int c = 0; c < len; c++) begin
        applyStimulus(lvl, 1'($urandom_range(0, 15) == 0), 1);
      end
    end

    applyStimulus(1'b0, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 4);
    checkOutput("t6_pre_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("t6_async");
    releaseAndCheck("t6");
    checkOutput("t6_no_glitch", 32'(glitch_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
